ff_addsub_serial: RTL

// - Modular add/subtract over prime field GF(P): out = (a + b) mod P or (a - b) mod P, selected per operation.
// - Limb-serial datapath: LIMB bits per cycle, so the 256-bit ECC field op does not need a full-width carry chain.
// - Sits under the point-add/point-double sequencers as the field add/sub primitive.
// - Uses the same start/done handshake as the existing field-arithmetic units.

---
 rtl/ff_pkg.sv | 18 +
 rtl/ff_limb_addsub.sv | 27 ++
 rtl/ff_addsub_serial.sv | 111 +++++++++++
 3 files changed

// File: rtl/ff_pkg.sv
// rtl/ff_pkg.sv - shared constants and enums for the prime-field arithmetic units
package ff_pkg;

   localparam logic [255:0] SECP256K1_P =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_e;

endpackage

// File: rtl/ff_limb_addsub.sv
// rtl/ff_limb_addsub.sv - one limb of a ripple add/subtract with carry/borrow in and out
module ff_limb_addsub #(
   parameter int LIMB = 64
) (
   input  logic [LIMB-1:0] x,
   input  logic [LIMB-1:0] y,
   input  logic            cin,
   input  logic            sub,
   output logic [LIMB-1:0] r,
   output logic            cout
);

   logic [LIMB:0] sum;

   // With a zero-extended subtraction, bit LIMB is set exactly when the result went negative.
   always_comb begin
      if (sub) begin
         sum = {1'b0, x} - {1'b0, y} - {{LIMB{1'b0}}, cin};
      end else begin
         sum = {1'b0, x} + {1'b0, y} + {{LIMB{1'b0}}, cin};
      end
   end

   assign r    = sum[LIMB-1:0];
   assign cout = sum[LIMB];

endmodule

// File: rtl/ff_addsub_serial.sv
// rtl/ff_addsub_serial.sv - limb-serial modular add/subtract over GF(P), start/done handshake
module ff_addsub_serial
   import ff_pkg::*;
#(
   parameter int               WIDTH = 256,
   parameter int               LIMB  = 64,
   parameter logic [WIDTH-1:0] P     = SECP256K1_P
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out
);

   localparam int NL   = WIDTH / LIMB;
   localparam int IDXW = (NL > 1) ? $clog2(NL) : 1;

   if (WIDTH % LIMB != 0) begin : g_bad_limb
      $error("ff_addsub_serial: WIDTH must be a multiple of LIMB");
   end

   state_e            state, next_state;
   logic [IDXW-1:0]   idx;
   logic [WIDTH-1:0]  a_sr, b_sr, s_sr, t_sr, sel;
   op_e               op_q;
   logic              c1, c2;
   logic              load, step, last;
   logic [LIMB-1:0]   p_limb, s_limb, t_limb;
   logic              s_cout, t_cout;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (last)  next_state = FIN;
         FIN:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      load = (state == IDLE) && start;
      step = (state == RUN);
      last = step && (idx == IDXW'(NL - 1));
   end

   assign p_limb = P[int'(idx) * LIMB +: LIMB];

   // s cell: a +/- b; t cell undoes or applies the modulus on s in the opposite direction.
   ff_limb_addsub #(.LIMB(LIMB)) u_s_cell (
      .x(a_sr[LIMB-1:0]), .y(b_sr[LIMB-1:0]), .cin(c1), .sub(op_q == OP_SUB),
      .r(s_limb), .cout(s_cout)
   );

   ff_limb_addsub #(.LIMB(LIMB)) u_t_cell (
      .x(s_limb), .y(p_limb), .cin(c2), .sub(op_q == OP_ADD),
      .r(t_limb), .cout(t_cout)
   );

   // Add: reduce when the raw sum overflowed or s-P did not borrow. Sub: add P back on borrow.
   always_comb begin
      if (op_q == OP_SUB) sel = c1 ? t_sr : s_sr;
      else                sel = (c1 || !c2) ? t_sr : s_sr;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         idx  <= '0;
         a_sr <= '0;
         b_sr <= '0;
         s_sr <= '0;
         t_sr <= '0;
         op_q <= OP_ADD;
         c1   <= 1'b0;
         c2   <= 1'b0;
         done <= 1'b0;
         out  <= '0;
      end else begin
         done <= (state == FIN);
         if (load) begin
            a_sr <= a;
            b_sr <= b;
            op_q <= op_e'(op);
            c1   <= 1'b0;
            c2   <= 1'b0;
            idx  <= '0;
         end else if (step) begin
            a_sr <= a_sr >> LIMB;
            b_sr <= b_sr >> LIMB;
            s_sr <= WIDTH'({s_limb, s_sr} >> LIMB);
            t_sr <= WIDTH'({t_limb, t_sr} >> LIMB);
            c1   <= s_cout;
            c2   <= t_cout;
            idx  <= idx + 1'b1;
         end
         if (state == FIN) out <= sel;
      end
   end

endmodule
